// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction fetch bus: imem port, redirect, and decode-side handshake
interface instr_fetch_if;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        err_o;

    // Fetch unit side
    modport master (
        output imem_addr_o,
        input  imem_data_i,
        input  redirect_i,
        input  redirect_pc_i,
        output instr_o,
        output pc_o,
        output valid_o,
        input  ready_i,
        output err_o
    );

    // Memory / pipeline side
    modport slave (
        input  imem_addr_o,
        output imem_data_i,
        output redirect_i,
        output redirect_pc_i,
        input  instr_o,
        input  pc_o,
        input  valid_o,
        output ready_i,
        input  err_o
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch with FIFO buffer and redirect; option macro FETCH_MISALIGN_CHECK_EN
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    instr_fetch_if.master bus
);
    localparam int          PW  = $clog2(QUEUE_DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   q_pc    [QUEUE_DEPTH];
    logic [31:0]   q_instr [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          valid;
    logic          pop;
    logic          push;

    assign full  = (count == CW'(QUEUE_DEPTH));
    assign valid = (count != '0);
    assign pop   = valid && bus.ready_i;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic err_q;
    logic misalign;

    assign misalign  = (bus.redirect_pc_i[1:0] != 2'b00);
    // A sticky error halts fetching until an aligned redirect restarts it
    assign push      = !bus.redirect_i && !err_q && (!full || pop);
    assign bus.err_o = err_q;
`else
    logic unused_pc_bits;

    // Low address bits are dropped: targets are forced word-aligned
    assign unused_pc_bits = ^bus.redirect_pc_i[1:0];
    assign push           = !bus.redirect_i && (!full || pop);
    assign bus.err_o      = 1'b0;
`endif

    assign bus.imem_addr_o = fetch_pc;
    assign bus.valid_o     = valid;
    assign bus.instr_o     = valid ? q_instr[rd_ptr] : NOP;
    assign bus.pc_o        = valid ? q_pc[rd_ptr]    : 32'h0000_0000;

    // Fetch PC, queue pointers and occupancy; redirect overrides push/pop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else if (bus.redirect_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
            if (misalign) begin
                err_q <= 1'b1;
            end else begin
                fetch_pc <= bus.redirect_pc_i;
                err_q    <= 1'b0;
            end
`else
            fetch_pc <= {bus.redirect_pc_i[31:2], 2'b00};
`endif
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Queue storage; stale contents are masked by valid, so no reset needed
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= bus.imem_data_i;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized bench for instr_fetch
module tb_instr_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          QD     = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic scramble;
    int   n_chk = 0;
    int   n_err = 0;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RST_PC), .QUEUE_DEPTH(QD)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

    assign bus.imem_data_i = scramble ? ((bus.imem_addr_o ^ 32'hC0DE_0000) ^ {bus.imem_addr_o[15:0], 16'h0})
                                      : bus.imem_addr_o;

    // Reference model: list of fetched {pc, instr} pairs plus next fetch address
    logic [63:0] mq[$];
    logic [31:0] m_fetch;
    logic        m_err;

    function automatic logic [31:0] word(input logic [31:0] a);
        return scramble ? ((a ^ 32'hC0DE_0000) ^ {a[15:0], 16'h0}) : a;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_fetch = RST_PC;
        m_err   = 1'b0;
    endtask

    task automatic model_step(input logic redir, input logic [31:0] tgt, input logic rdy);
        int n;
        bit pop;
        n   = mq.size();
        pop = (n != 0) && rdy;
        if (redir) begin
            mq.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) begin
                m_err = 1'b1;
            end else begin
                m_fetch = tgt;
                m_err   = 1'b0;
            end
`else
            m_fetch = tgt & 32'hFFFF_FFFC;
`endif
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_err && (n < QD || pop)) begin
                mq.push_back({m_fetch, word(m_fetch)});
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        e_valid = (mq.size() != 0);
        e_pc    = e_valid ? mq[0][63:32] : 32'h0;
        e_instr = e_valid ? mq[0][31:0]  : NOP;
        chk("valid", {31'b0, bus.valid_o}, {31'b0, e_valid});
        chk("pc", bus.pc_o, e_pc);
        chk("instr", bus.instr_o, e_instr);
        chk("imem_addr", bus.imem_addr_o, m_fetch);
        chk("err", {31'b0, bus.err_o}, {31'b0, m_err});
    endtask

    // One clock: drive inputs after the falling edge, check, then advance the model
    task automatic cyc(input logic redir, input logic [31:0] tgt, input logic rdy);
        @(negedge clk_i);
        bus.redirect_i    = redir;
        bus.redirect_pc_i = tgt;
        bus.ready_i       = rdy;
        #1;
        check_model();
        model_step(redir, tgt, rdy);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, {31'b0, bus.valid_o}, 32'h0);
        chk({tag, "_instr"}, bus.instr_o, NOP);
        chk({tag, "_pc"}, bus.pc_o, 32'h0);
        chk({tag, "_err"}, {31'b0, bus.err_o}, 32'h0);
        chk({tag, "_addr"}, bus.imem_addr_o, RST_PC);
    endtask

    initial begin
        logic [31:0] tgt;
        logic        rdy;
        logic        rd;
        rst_ni            = 1'b0;
        scramble          = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.ready_i       = 1'b0;
        model_reset();

        // Reset state, then release between edges
        @(negedge clk_i);
        #1;
        chk_reset_state("reset");
        #6;
        rst_ni = 1'b1;

        // Stream with memory word = address
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("stream_valid", {31'b0, bus.valid_o}, (i > 0) ? 32'h1 : 32'h0);
            chk("stream_pc", bus.pc_o, (i > 0) ? RST_PC + 32'(4 * (i - 1)) : 32'h0);
            chk("stream_instr", bus.instr_o, (i > 0) ? RST_PC + 32'(4 * (i - 1)) : NOP);
        end

        // Asynchronous reset mid-stream
        @(negedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk_reset_state("async_rst");
        model_reset();
        scramble = 1'b1;
        #3;
        rst_ni = 1'b1;

        // Backpressure from reset: queue saturates, fetch address stops
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("bp_addr", bus.imem_addr_o, RST_PC + 32'(4 * QD));
        chk("bp_head", bus.pc_o, RST_PC);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("bp_resume_pc", bus.pc_o, RST_PC + 32'(4 * k));
        end

        // Redirect with full queue
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h100, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("redir_bubble", {31'b0, bus.valid_o}, 32'h0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("redir_pc0", bus.pc_o, 32'h100);
        cyc(1'b0, 32'h0, 1'b1);
        chk("redir_pc1", bus.pc_o, 32'h104);

        // Address wrap
        cyc(1'b1, 32'hFFFF_FFF8, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("wrap_bubble", {31'b0, bus.valid_o}, 32'h0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("wrap_pc0", bus.pc_o, 32'hFFFF_FFF8);
        cyc(1'b0, 32'h0, 1'b1);
        chk("wrap_pc1", bus.pc_o, 32'hFFFF_FFFC);
        cyc(1'b0, 32'h0, 1'b1);
        chk("wrap_pc2", bus.pc_o, 32'h0000_0000);

        // Misaligned redirect
        cyc(1'b1, 32'h102, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("mis_err", {31'b0, bus.err_o}, 32'h1);
            chk("mis_valid", {31'b0, bus.valid_o}, 32'h0);
        end
        cyc(1'b1, 32'h200, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("mis_clear_err", {31'b0, bus.err_o}, 32'h0);
        chk("mis_clear_valid", {31'b0, bus.valid_o}, 32'h0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("mis_restart_pc", bus.pc_o, 32'h200);
`else
        cyc(1'b0, 32'h0, 1'b1);
        chk("mis_err", {31'b0, bus.err_o}, 32'h0);
        chk("mis_valid", {31'b0, bus.valid_o}, 32'h0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("mis_pc0", bus.pc_o, 32'h100);
        cyc(1'b0, 32'h0, 1'b1);
        chk("mis_pc1", bus.pc_o, 32'h104);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = $urandom & 32'hFFFF_FFFC;
                1:       tgt = 32'hFFFF_FFF0 + ($urandom_range(0, 3) * 4);
                2:       tgt = $urandom;
                default: tgt = $urandom_range(0, 255) * 4;
            endcase
            cyc(rd, tgt, rdy);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
